test_layer_4: RTL and testbench

TEST_LAYER_4 -- requirements
Module: test_layer_4

---
 rtl/test_layer_4.sv | 92 +++++++++
 tb/tb_test_layer_4.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/test_layer_4.sv
`timescale 1ns/1ps
// test_layer_4: single binary convolution layer (XNOR-popcount + threshold).
// Input map, kernels and thresholds are elaboration-time constants; all
// 784 output neurons are evaluated combinationally and captured in out_map.
//
// Ports:
//   clk   rising-edge system clock
//   rstn  asynchronous active-low reset
//
// Observation-only internals: out_map[783:0], valid, P5000, P5001.
module test_layer_4 #(
    // 2 ch x 16 x 16, bit c*256 + y*16 + x; default checkerboard (x+y+c even -> 1)
    parameter logic [511:0] IN_MAP  = {{8{32'h5555AAAA}}, {8{32'hAAAA5555}}},
    // 4 out x 2 in x 3 x 3, bit k*18 + c*9 + ky*3 + kx; 1 = +1, 0 = -1
    parameter logic [71:0]  WEIGHTS = {72{1'b1}},
    // 4 x 5-bit unsigned, bits [5k+4:5k] for output channel k
    parameter logic [19:0]  THRESH  = {4{5'd9}}
) (
    input logic clk,
    input logic rstn
);

    localparam int unsigned IN_DIM   = 16;
    localparam int unsigned IN_PLANE = IN_DIM * IN_DIM;
    localparam int unsigned IN_CH    = 2;
    localparam int unsigned OUT_CH   = 4;
    localparam int unsigned KDIM     = 3;
    localparam int unsigned KAREA    = KDIM * KDIM;
    localparam int unsigned TAPS     = IN_CH * KAREA;
    localparam int unsigned OUT_DIM  = IN_DIM - KDIM + 1;
    localparam int unsigned OUT_PLANE = OUT_DIM * OUT_DIM;
    localparam int unsigned OUT_BITS = OUT_CH * OUT_PLANE;
    localparam int unsigned MW       = 5;
    localparam int unsigned TW       = 5;

    logic [OUT_BITS-1:0] conv_c;
    logic [OUT_BITS-1:0] out_map;
    logic                valid;
    logic                P5000;
    logic                P5001;

    // One neuron per (k, y, x): XNOR each of the 18 window taps with its
    // weight, count matches, compare against the channel threshold.
    for (genvar k = 0; k < OUT_CH; k++) begin : g_ch
        for (genvar y = 0; y < OUT_DIM; y++) begin : g_row
            for (genvar x = 0; x < OUT_DIM; x++) begin : g_col
                logic [TAPS-1:0] match_c;
                logic [MW-1:0]   m_c;

                for (genvar t = 0; t < TAPS; t++) begin : g_tap
                    localparam int unsigned C    = t / KAREA;
                    localparam int unsigned KY   = (t % KAREA) / KDIM;
                    localparam int unsigned KX   = t % KDIM;
                    localparam int unsigned IIDX = C * IN_PLANE + (y + KY) * IN_DIM + (x + KX);
                    localparam int unsigned WIDX = k * TAPS + t;
                    assign match_c[t] = ~(IN_MAP[IIDX] ^ WEIGHTS[WIDX]);
                end

                // Popcount of matches, 0..18
                always_comb begin
                    m_c = '0;
                    for (int i = 0; i < TAPS; i++) begin
                        m_c = m_c + MW'(match_c[i]);
                    end
                end

                // Thresholds above 18 can never be reached, giving a constant 0
                assign conv_c[k * OUT_PLANE + y * OUT_DIM + x] =
                    (m_c >= THRESH[k * TW +: TW]);
            end
        end
    end

    // Capture the layer result; valid marks the first capture after reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_map <= '0;
            valid   <= 1'b0;
        end else begin
            out_map <= conv_c;
            valid   <= 1'b1;
        end
    end

    assign P5000 = out_map[0];
    assign P5001 = out_map[1];

    // Keeps the observation-only state referenced (no output ports exist)
    logic obs_unused;
    assign obs_unused = ^{out_map, valid, P5000, P5001};

endmodule

// File: tb/tb_test_layer_4.sv
`timescale 1ns/1ps
module tb_test_layer_4;

    localparam logic [511:0] DEF_MAP = {{8{32'h5555AAAA}}, {8{32'hAAAA5555}}};
    localparam logic [71:0]  ONES_W  = {72{1'b1}};

    function automatic logic [511:0] gen_bits(input logic [31:0] seed);
        logic [511:0] r;
        logic [31:0]  s;
        r = '0;
        s = seed;
        for (int i = 0; i < 512; i++) begin
            s = s ^ (s << 13);
            s = s ^ (s >> 17);
            s = s ^ (s << 5);
            r[i] = s[7];
        end
        return r;
    endfunction

    localparam logic [511:0] MIX_MAP  = gen_bits(32'h1234_5678);
    localparam logic [511:0] MIX_WRAW = gen_bits(32'h9E37_79B9);
    localparam logic [71:0]  MIX_W    = MIX_WRAW[71:0];
    localparam logic [19:0]  MIX_TH   = {5'd11, 5'd10, 5'd8, 5'd9};

    logic clk;
    logic rstn;

    int checks   = 0;
    int failures = 0;
    int edges    = 0;
    bit run      = 1'b0;

    logic [783:0] exp_def, exp_t10, exp_o18, exp_o19, exp_z0, exp_z1, exp_mix;
    logic [783:0] snap;

    test_layer_4 u_dut (.clk(clk), .rstn(rstn));
    test_layer_4 #(.THRESH({4{5'd10}})) u_t10 (.clk(clk), .rstn(rstn));
    test_layer_4 #(.IN_MAP({512{1'b1}}), .WEIGHTS(ONES_W), .THRESH({4{5'd18}})) u_o18 (.clk(clk), .rstn(rstn));
    test_layer_4 #(.IN_MAP({512{1'b1}}), .WEIGHTS(ONES_W), .THRESH({4{5'd19}})) u_o19 (.clk(clk), .rstn(rstn));
    test_layer_4 #(.IN_MAP({512{1'b0}}), .WEIGHTS(ONES_W), .THRESH({4{5'd0}})) u_z0 (.clk(clk), .rstn(rstn));
    test_layer_4 #(.IN_MAP({512{1'b0}}), .WEIGHTS(ONES_W), .THRESH({4{5'd1}})) u_z1 (.clk(clk), .rstn(rstn));
    test_layer_4 #(.IN_MAP(MIX_MAP), .WEIGHTS(MIX_W), .THRESH(MIX_TH)) u_mix (.clk(clk), .rstn(rstn));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: direct XNOR-popcount over every output neuron
    function automatic logic [783:0] ref_map(input logic [511:0] im, input logic [71:0] w,
                                             input logic [19:0] th);
        logic [783:0] r;
        int m;
        r = '0;
        for (int k = 0; k < 4; k++)
            for (int y = 0; y < 14; y++)
                for (int x = 0; x < 14; x++) begin
                    m = 0;
                    for (int c = 0; c < 2; c++)
                        for (int ky = 0; ky < 3; ky++)
                            for (int kx = 0; kx < 3; kx++)
                                if (im[c*256 + (y+ky)*16 + (x+kx)] == w[k*18 + c*9 + ky*3 + kx])
                                    m++;
                    r[k*196 + y*14 + x] = (m >= int'(th[k*5 +: 5]));
                end
        return r;
    endfunction

    task automatic chk_map(input string name, input logic [783:0] act, input logic [783:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
        end
    endtask

    task automatic chk_inst(input string name, input logic [783:0] map, input logic v,
                            input logic p0, input logic p1, input logic [783:0] model,
                            input bit active);
        logic [783:0] e;
        e = active ? model : '0;
        chk_map({name, "_map"}, map, e);
        chk_bit({name, "_valid"}, v, active);
        chk_bit({name, "_p5000"}, p0, e[0]);
        chk_bit({name, "_p5001"}, p1, e[1]);
    endtask

    // Rising edges seen since the most recent reset release (saturating)
    always @(posedge clk or negedge rstn) begin
        if (!rstn) edges <= 0;
        else if (edges < 2) edges <= edges + 1;
    end

    // Every-cycle comparison of all instances against the model
    always @(posedge clk) begin
        #2;
        if (run) begin
            bit act;
            act = (rstn === 1'b1) && (edges > 0);
            chk_inst("def", u_dut.out_map, u_dut.valid, u_dut.P5000, u_dut.P5001, exp_def, act);
            chk_inst("t10", u_t10.out_map, u_t10.valid, u_t10.P5000, u_t10.P5001, exp_t10, act);
            chk_inst("o18", u_o18.out_map, u_o18.valid, u_o18.P5000, u_o18.P5001, exp_o18, act);
            chk_inst("o19", u_o19.out_map, u_o19.valid, u_o19.P5000, u_o19.P5001, exp_o19, act);
            chk_inst("z0", u_z0.out_map, u_z0.valid, u_z0.P5000, u_z0.P5001, exp_z0, act);
            chk_inst("z1", u_z1.out_map, u_z1.valid, u_z1.P5000, u_z1.P5001, exp_z1, act);
            chk_inst("mix", u_mix.out_map, u_mix.valid, u_mix.P5000, u_mix.P5001, exp_mix, act);
        end
    end

    task automatic immediate_reset_check(input string name);
        chk_bit({name, "_async_p5000"}, u_dut.P5000, 1'b0);
        chk_bit({name, "_async_p5001"}, u_dut.P5001, 1'b0);
        chk_bit({name, "_async_valid"}, u_dut.valid, 1'b0);
        chk_map({name, "_async_map"}, u_mix.out_map, '0);
    endtask

    initial begin
        rstn = 1'b0;
        exp_def = ref_map(DEF_MAP, ONES_W, {4{5'd9}});
        exp_t10 = ref_map(DEF_MAP, ONES_W, {4{5'd10}});
        exp_o18 = ref_map({512{1'b1}}, ONES_W, {4{5'd18}});
        exp_o19 = ref_map({512{1'b1}}, ONES_W, {4{5'd19}});
        exp_z0  = ref_map({512{1'b0}}, ONES_W, {4{5'd0}});
        exp_z1  = ref_map({512{1'b0}}, ONES_W, {4{5'd1}});
        exp_mix = ref_map(MIX_MAP, MIX_W, MIX_TH);
        run = 1'b1;

        // Pin the model itself with hand-derived results
        chk_map("model_def", exp_def, {784{1'b1}});
        chk_map("model_t10", exp_t10, {784{1'b0}});
        chk_map("model_o18", exp_o18, {784{1'b1}});
        chk_map("model_o19", exp_o19, {784{1'b0}});
        chk_map("model_z0", exp_z0, {784{1'b1}});
        chk_map("model_z1", exp_z1, {784{1'b0}});

        #10 rstn = 1'b1;
        #20;  // t=30, two edges after release
        chk_bit("lit_def_p5000", u_dut.P5000, 1'b1);
        chk_bit("lit_def_p5001", u_dut.P5001, 1'b1);
        chk_bit("lit_def_valid", u_dut.valid, 1'b1);
        chk_map("lit_def_map", u_dut.out_map, {784{1'b1}});
        chk_bit("lit_t10_p5000", u_t10.P5000, 1'b0);
        chk_map("lit_t10_map", u_t10.out_map, {784{1'b0}});
        chk_map("lit_o18_map", u_o18.out_map, {784{1'b1}});
        chk_map("lit_o19_map", u_o19.out_map, {784{1'b0}});
        chk_map("lit_z0_map", u_z0.out_map, {784{1'b1}});
        chk_map("lit_z1_map", u_z1.out_map, {784{1'b0}});

        // One-cycle reset pulse at t=100
        #70 rstn = 1'b0;
        #1 immediate_reset_check("pulse100");
        #9 rstn = 1'b1;
        #20;  // t=130, two edges after release
        chk_map("relaunch_def_map", u_dut.out_map, {784{1'b1}});
        chk_bit("relaunch_def_valid", u_dut.valid, 1'b1);

        // Randomized mid-cycle reset pulses of random length
        for (int n = 0; n < 8; n++) begin
            int unsigned wait_cyc, off, hold;
            wait_cyc = $urandom_range(20, 3);
            off      = $urandom_range(8, 3);
            hold     = $urandom_range(3, 1);
            @(posedge clk);
            repeat (wait_cyc - 1) @(posedge clk);
            #(off);
            rstn = 1'b0;
            #1 immediate_reset_check("rand");
            #(hold * 10 - 1);
            rstn = 1'b1;
        end

        // Stability over 20 cycles once valid
        repeat (3) @(posedge clk);
        #2 snap = u_mix.out_map;
        chk_map("snap_mix_model", snap, exp_mix);
        repeat (20) @(posedge clk);
        #2 chk_map("stable_mix_20cyc", u_mix.out_map, snap);
        chk_map("stable_def_20cyc", u_dut.out_map, {784{1'b1}});

        #1 run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
